// File: rtl/mips_pkg.sv
// Constants and types shared by the program loader, instruction memory and core.
package mips_pkg;

  localparam int         MEM_ADDR_W        = 5;
  localparam int         MEM_DEPTH         = 1 << MEM_ADDR_W;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_SYNC,
    LD_COUNT,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Assembles little-endian 32-bit words from bytes and keeps a running XOR checksum.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [1:0]  index,
  output logic [7:0]  csum
);

  logic [31:0] shift;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift <= '0;
      index <= '0;
      csum  <= '0;
    end else if (load) begin
      shift <= word;
      index <= index + 2'd1;
      csum  <= csum ^ data;
    end
  end

  // Word including the byte currently presented, so the 4th byte needs no extra cycle.
  assign word = {data, shift[31:8]};

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream into instruction memory, then releases the core.
module program_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W    = MEM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  ld_state_t         state, state_next;
  logic              accept, sync_hit, load, word_done;
  logic              count_bad, csum_ok, last_word;
  logic [31:0]       word;
  logic [1:0]        index;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;

  assign accept    = in_valid && in_ready;
  assign sync_hit  = accept && (in_data == SYNC_BYTE) &&
                     (state == LD_SYNC || state == LD_ERR);
  assign load      = accept && (state == LD_DATA);
  assign word_done = load && (index == 2'd3);
  assign count_bad = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign csum_ok   = (in_data == csum);
  assign last_word = (remaining == CNT_W'(1));

  word_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (sync_hit),
    .load  (load),
    .data  (in_data),
    .word  (word),
    .index (index),
    .csum  (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LD_SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LD_SYNC:  if (sync_hit) state_next = LD_COUNT;
      LD_COUNT: if (accept)   state_next = count_bad ? LD_ERR : LD_DATA;
      LD_DATA:  if (word_done && last_word) state_next = LD_CSUM;
      LD_CSUM:  if (accept)   state_next = csum_ok ? LD_RUN : LD_ERR;
      LD_RUN:   state_next = LD_RUN;
      LD_ERR:   if (sync_hit) state_next = LD_COUNT;
      default:  state_next = LD_SYNC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      LD_RUN: begin
        in_ready  = 1'b0;
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      LD_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      mem_we <= 1'b0;
      if (sync_hit) addr <= '0;
      if (state == LD_COUNT && accept) remaining <= CNT_W'(in_data);
      if (word_done) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frame-level reference model, randomized frames and gaps.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned due;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] fw [32];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  program_loader #(.ADDR_W(5), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%h, none expected", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", mem_wdata, mon_e.data);
        chk("wr_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // csum_mode: -1 correct checksum, -2 corrupted checksum, >=0 literal byte.
  // stop_after: number of data bytes to send before abandoning the frame (-1 = whole frame).
  task automatic send_frame(input int n_field, input int maxgap, input int csum_mode,
                            input int stop_after);
    logic [7:0] acc;
    logic [7:0] b;
    logic [7:0] cs;
    int         sent;
    acc  = 8'h00;
    sent = 0;
    drive(8'hA5);
    drive(8'(n_field));
    chk("err_after_sync", 32'(error), 32'd0);
    if (n_field < 1 || n_field > 32) begin
      idle(1);
      chk("bad_count_err", 32'(error), 32'd1);
      chk("bad_count_cpurst", 32'(cpu_reset), 32'd1);
      return;
    end
    for (int w = 0; w < n_field; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (stop_after >= 0 && sent == stop_after) return;
        idle($urandom_range(0, maxgap));
        b = fw[w][8*k +: 8];
        drive(b);
        sent++;
        acc = acc ^ b;
        if (k == 3) exp_q.push_back('{addr: 5'(w), data: fw[w], due: cyc + 1});
      end
    end
    if (csum_mode == -1)      cs = acc;
    else if (csum_mode == -2) cs = acc ^ 8'($urandom_range(1, 255));
    else                      cs = 8'(csum_mode);
    idle($urandom_range(0, maxgap));
    drive(cs);
    chk("pre_csum_done", 32'(done), 32'd0);
    idle(1);
    if (cs == acc) begin
      chk("run_done", 32'(done), 32'd1);
      chk("run_cpurst", 32'(cpu_reset), 32'd0);
      chk("run_ready", 32'(in_ready), 32'd0);
      chk("run_err", 32'(error), 32'd0);
    end else begin
      chk("csum_err", 32'(error), 32'd1);
      chk("csum_cpurst", 32'(cpu_reset), 32'd1);
      chk("csum_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;

    drive(8'h00);
    drive(8'hFF);
    idle(1);
    chk("garbage_err", 32'(error), 32'd0);
    chk("garbage_done", 32'(done), 32'd0);
    chk("garbage_ready", 32'(in_ready), 32'd1);

    // Directed two-word frame; checksum byte follows from the XOR rule.
    fw[0] = 32'h12345678;
    fw[1] = 32'hDEADBEEF;
    send_frame(2, 0, -1, -1);
    idle(2);
    chk("run_ready_hold", 32'(in_ready), 32'd0);

    do_reset();
    send_frame(2, 0, 8'h00, -1);
    send_frame(2, 0, -1, -1);

    do_reset();
    send_frame(0, 0, -1, -1);
    send_frame(33, 0, -1, -1);

    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(1, 32);
      for (int w = 0; w < 32; w++) fw[w] = $urandom;
      do_reset();
      send_frame(n, 0, (it == 3) ? -2 : -1, -1);
      do_reset();
      send_frame(n, 5, (it == 3) ? -2 : -1, -1);
    end

    for (int w = 0; w < 32; w++) fw[w] = $urandom;
    do_reset();
    send_frame(32, 0, -1, 6);
    do_reset();
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_cpurst", 32'(cpu_reset), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_err", 32'(error), 32'd0);
    send_frame(32, 0, -1, -1);

    idle(5);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
